clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Multi-channel clock-gating controller with idle hysteresis and a wake-up handshake. It has NUM_CH independent channels. Each channel drives one xilinx_clk_gating cell from a registered enable, using a four-state FSM. The block sits between the core/peripheral power-management logic and the per-domain gated clocks. It turns a manual enable into automatic gating after a programmable idle period, and provides a safe req/ack wake path.

## Interface
- NUM_CH, 4: number of independent gated-clock channels (≥1).
- HOLD_W, 8: width of the idle-hysteresis counter and hold_cycles_i.
- WAKE_LAT, 2: cycles spent in WAKE before a channel is declared ON (≥1).
- RESET_ON, 1: 1 = channels leave reset in ON; 0 = in OFF.
- clk_i  in  1  free-running clock; one clock, everything on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- scan_cg_en_i  in  1  forces every gated clock running (drives the cell test enable); FSMs unaffected.
- hold_cycles_i  in  HOLD_W  idle hysteresis H, shared by all channels.
- sw_en_i  in  NUM_CH  per-channel force-on; blocks gating while high.
- idle_i  in  NUM_CH  per-channel consumer idle indication.
- wake_req_i  in  NUM_CH  per-channel wake request (level, held until ack).
- wake_ack_o  out  NUM_CH  per-channel wake acknowledge (registered).
- clk_en_o  out  NUM_CH  registered enable presented to each gating cell (status).
- gated_clk_o  out  NUM_CH  gated clocks.

## Operation
- States per channel: ON, COUNT, OFF, WAKE. Define the wake condition as wake_req_i | sw_en_i | ~idle_i.
- ON: en=1.
  - If idle_i & ~sw_en_i & ~wake_req_i: go to COUNT and load cnt ← hold_cycles_i. H is sampled only on this transition.
- COUNT: en=1.
  - If ~idle_i | sw_en_i | wake_req_i: go to ON. The abort has priority over expiry.
  - Otherwise, if cnt==0: go to OFF.
  - Otherwise: cnt ← cnt−1.
- OFF: en=0.
  - If the wake condition holds: go to WAKE, en=1, and load wcnt ← WAKE_LAT−1.
- WAKE: en=1.
  - If wcnt==0: go to ON.
  - Otherwise: wcnt ← wcnt−1.
  - Idle or request changes are ignored until ON is reached. There is no re-gating from WAKE.
- Acknowledge: wake_ack_o[i] ← (state==ON) & wake_req_i[i], registered.
  - Four-phase handshake: req rises, ack rises, req falls, ack falls on the next edge.
  - A req asserted while ON is acked on the next edge.
  - A req arriving during COUNT aborts to ON and is acked one edge later.
- clk_en_o = en register. gated_clk_o follows en through the cell latch, so it is glitch-free.
- scan_cg_en_i=1: gated_clk_o runs regardless of en. clk_en_o still reports the FSM value.

## Timing
- Reset: state = ON if RESET_ON else OFF; clk_en_o = RESET_ON replicated; wake_ack_o = 0; cnt = 0; wcnt = 0.
- Reset asserted mid-COUNT or mid-WAKE restores the reset values on the next edge. No ack is emitted.
- Gating latency: idle first sampled high (with sw_en and req low) at edge t, in ON, gives clk_en_o low after edge t+H+1.
  - H=0: low after edge t+1.
  - H=2^HOLD_W−1: no wrap; the counter stops at 0.
- Wake latency: wake condition sampled at edge t, in OFF, gives:
  - clk_en_o high after edge t.
  - state ON after edge t+WAKE_LAT.
  - wake_ack_o high after edge t+WAKE_LAT+1, if req is still held.
- Gated clock edges follow clk_en_o by the cell latch, i.e. the first full clock after en changes.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Structure
- clk_gate_ctrl_pkg holds:
  - cg_state_e enum (ON, COUNT, OFF, WAKE), 2-bit encoding.
  - Reset-state selection function of RESET_ON.
- Sub-module clk_gate_ch contains one channel: the FSM, the cnt and wcnt registers, the ack register, and the xilinx_clk_gating instance. The top level contains only a generate loop over NUM_CH plus port slicing.

## Test plan
- Reset with RESET_ON=1, rst_i high for 2 cycles → clk_en_o=4'hF, wake_ack_o=0. Gated clocks toggle.
- Channel 0, H=5, idle_i[0] raised at edge t → clk_en_o[0] drops after edge t+6. Channels 1–3 stay high.
- Channel 1 in COUNT with H=10: drop idle_i[1] at cnt=3 → back to ON next edge, clk_en_o[1] never falls. Re-idle reloads H=10.
- Channel 2 in OFF, WAKE_LAT=2: wake_req_i[2] raised at edge t → clk_en_o[2] high after t, wake_ack_o[2] high after t+3. Drop req → ack low next edge.
- Channel 3 OFF with scan_cg_en_i=1 → gated_clk_o[3] toggles every cycle while clk_en_o[3]=0. sw_en_i[3] held high → channel never leaves ON.
- rst_i asserted during WAKE on channel 2 → state ON (RESET_ON=1), ack never pulses. Repeat with H=0 → gating after 2 edges.

Source files
------------

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types for the clock-gating controller: per-channel FSM states and the
// reset-state selection.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_COUNT = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } cg_state_e;

  function automatic cg_state_e reset_state(input bit reset_on);
    return reset_on ? ST_ON : ST_OFF;
  endfunction

endpackage

// File: rtl/clk_gate_ch.sv
// One gated-clock channel: idle-hysteresis FSM, wake-latency counter,
// registered wake acknowledge and the gating cell.
module clk_gate_ch
  import clk_gate_ctrl_pkg::*;
#(
  parameter int HOLD_W   = 8,
  parameter int WAKE_LAT = 2,
  parameter int RESET_ON = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scan_cg_en_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  input  logic              sw_en_i,
  input  logic              idle_i,
  input  logic              wake_req_i,
  output logic              wake_ack_o,
  output logic              clk_en_o,
  output logic              gated_clk_o
);

  localparam int WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WCNT_W-1:0] WAKE_LOAD = WCNT_W'(WAKE_LAT - 1);

  cg_state_e         state;
  logic [HOLD_W-1:0] cnt;
  logic [WCNT_W-1:0] wcnt;
  logic              en;
  logic              ack;
  logic              wake_cond;

  assign wake_cond = wake_req_i | sw_en_i | ~idle_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= reset_state(RESET_ON != 0);
      en    <= (RESET_ON != 0);
      ack   <= 1'b0;
      cnt   <= '0;
      wcnt  <= '0;
    end else begin
      ack <= (state == ST_ON) & wake_req_i;
      case (state)
        ST_ON: begin
          en <= 1'b1;
          if (idle_i & ~sw_en_i & ~wake_req_i) begin
            state <= ST_COUNT;
            cnt   <= hold_cycles_i;
          end
        end
        ST_COUNT: begin
          // Abort outranks expiry so a late request never sees the clock drop.
          if (~idle_i | sw_en_i | wake_req_i) begin
            state <= ST_ON;
            en    <= 1'b1;
          end else if (cnt == '0) begin
            state <= ST_OFF;
            en    <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_OFF: begin
          if (wake_cond) begin
            state <= ST_WAKE;
            en    <= 1'b1;
            wcnt  <= WAKE_LOAD;
          end else begin
            en <= 1'b0;
          end
        end
        ST_WAKE: begin
          en <= 1'b1;
          if (wcnt == '0) state <= ST_ON;
          else            wcnt  <= wcnt - 1'b1;
        end
        default: state <= reset_state(RESET_ON != 0);
      endcase
    end
  end

  assign wake_ack_o = ack;
  assign clk_en_o   = en;

  xilinx_clk_gating u_cg (
    .clk_i     (clk_i),
    .en_i      (en),
    .test_en_i (scan_cg_en_i),
    .gclk_o    (gated_clk_o)
  );

endmodule

// File: rtl/xilinx_clk_gating.sv
// Latch-based clock gating cell: enable is captured while clk is low, so the
// gated clock never glitches. test_en_i forces the clock through.
module xilinx_clk_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic gclk_o
);

  logic en_lat;

  always_latch begin
    if (!clk_i) en_lat <= en_i | test_en_i;
  end

  assign gclk_o = clk_i & en_lat;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: NUM_CH independent channels sharing
// the clock, reset, scan override and hysteresis setting.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int HOLD_W   = 8,
  parameter int WAKE_LAT = 2,
  parameter int RESET_ON = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scan_cg_en_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  input  logic [NUM_CH-1:0] sw_en_i,
  input  logic [NUM_CH-1:0] idle_i,
  input  logic [NUM_CH-1:0] wake_req_i,
  output logic [NUM_CH-1:0] wake_ack_o,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] gated_clk_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gate_ch #(
      .HOLD_W   (HOLD_W),
      .WAKE_LAT (WAKE_LAT),
      .RESET_ON (RESET_ON)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .scan_cg_en_i  (scan_cg_en_i),
      .hold_cycles_i (hold_cycles_i),
      .sw_en_i       (sw_en_i[i]),
      .idle_i        (idle_i[i]),
      .wake_req_i    (wake_req_i[i]),
      .wake_ack_o    (wake_ack_o[i]),
      .clk_en_o      (clk_en_o[i]),
      .gated_clk_o   (gated_clk_o[i])
    );
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (NUM_CH=4, HOLD_W=8, WAKE_LAT=2, RESET_ON=1).
module tb_clk_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       scan;
  logic [7:0] hold;
  logic [3:0] sw_en;
  logic [3:0] idle;
  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] en;
  logic [3:0] gclk;

  int errors = 0;
  int checks = 0;
  int g0 = 0, g1 = 0, g2 = 0, g3 = 0;
  int a0, a1, a3;

  clk_gate_ctrl #(
    .NUM_CH   (4),
    .HOLD_W   (8),
    .WAKE_LAT (2),
    .RESET_ON (1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .scan_cg_en_i  (scan),
    .hold_cycles_i (hold),
    .sw_en_i       (sw_en),
    .idle_i        (idle),
    .wake_req_i    (req),
    .wake_ack_o    (ack),
    .clk_en_o      (en),
    .gated_clk_o   (gclk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge gclk[0]) g0++;
  always @(posedge gclk[1]) g1++;
  always @(posedge gclk[2]) g2++;
  always @(posedge gclk[3]) g3++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; scan = 1'b0; hold = 8'd5; sw_en = '0; idle = '0; req = '0;
    tick(2);
    checks++; if (en !== 4'hF) begin errors++; $display("FAIL reset_en got=%h exp=%h", en, 4'hF); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack got=%h exp=%h", ack, 4'h0); end
    rst = 1'b0;
    tick(1);
    a0 = g0; a1 = g1; a3 = g3;
    tick(3);
    checks++; if (g0 !== a0 + 3) begin errors++; $display("FAIL reset_gclk0 got=%0d exp=%0d", g0 - a0, 3); end
    checks++; if (g3 !== a3 + 3) begin errors++; $display("FAIL reset_gclk3 got=%0d exp=%0d", g3 - a3, 3); end
  endtask

  task automatic test_gating;
    hold = 8'd5; idle = 4'b0001;
    tick(1);
    tick(5);
    checks++; if (en !== 4'hF) begin errors++; $display("FAIL gate_hold got=%h exp=%h", en, 4'hF); end
    tick(1);
    checks++; if (en !== 4'b1110) begin errors++; $display("FAIL gate_drop got=%h exp=%h", en, 4'b1110); end
    a0 = g0; a1 = g1;
    tick(3);
    checks++; if (g0 !== a0) begin errors++; $display("FAIL gclk0_stopped got=%0d exp=%0d", g0 - a0, 0); end
    checks++; if (g1 !== a1 + 3) begin errors++; $display("FAIL gclk1_running got=%0d exp=%0d", g1 - a1, 3); end
    idle = 4'b0000;
    tick(1);
    checks++; if (en[0] !== 1'b1) begin errors++; $display("FAIL wake0_en got=%b exp=%b", en[0], 1'b1); end
    tick(2);
    req = 4'b0001;
    tick(1);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL ack_on got=%b exp=%b", ack, 4'b0001); end
    req = 4'b0000;
    tick(1);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL ack_on_fall got=%b exp=%b", ack, 4'b0000); end
  endtask

  task automatic test_abort;
    hold = 8'd10; idle = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      checks++; if (en[1] !== 1'b1) begin errors++; $display("FAIL abort_count k=%0d got=%b exp=%b", k, en[1], 1'b1); end
    end
    idle = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++; if (en[1] !== 1'b1) begin errors++; $display("FAIL abort_on k=%0d got=%b exp=%b", k, en[1], 1'b1); end
    end
    idle = 4'b0010;
    tick(11);
    checks++; if (en[1] !== 1'b1) begin errors++; $display("FAIL reload_hold got=%b exp=%b", en[1], 1'b1); end
    tick(1);
    checks++; if (en[1] !== 1'b0) begin errors++; $display("FAIL reload_drop got=%b exp=%b", en[1], 1'b0); end
  endtask

  task automatic test_wake_handshake;
    hold = 8'd0; idle = 4'b0110;
    tick(1);
    checks++; if (en[2] !== 1'b1) begin errors++; $display("FAIL h0_hold got=%b exp=%b", en[2], 1'b1); end
    tick(1);
    checks++; if (en[2] !== 1'b0) begin errors++; $display("FAIL h0_drop got=%b exp=%b", en[2], 1'b0); end
    req = 4'b0100;
    tick(1);
    checks++; if (en[2] !== 1'b1) begin errors++; $display("FAIL wake_en got=%b exp=%b", en[2], 1'b1); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL wake_ack_t got=%b exp=%b", ack, 4'h0); end
    tick(2);
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL wake_ack_t2 got=%b exp=%b", ack, 4'h0); end
    tick(1);
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL wake_ack_t3 got=%b exp=%b", ack, 4'b0100); end
    req = 4'b0000;
    tick(1);
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL wake_ack_fall got=%b exp=%b", ack, 4'h0); end
    tick(2);
    checks++; if (en !== 4'b1001) begin errors++; $display("FAIL regate got=%b exp=%b", en, 4'b1001); end
  endtask

  task automatic test_req_during_count;
    hold = 8'd5; idle = 4'b1110;
    tick(2);
    req = 4'b1000;
    tick(1);
    checks++; if (ack[3] !== 1'b0) begin errors++; $display("FAIL cnt_req_ack0 got=%b exp=%b", ack[3], 1'b0); end
    checks++; if (en[3] !== 1'b1) begin errors++; $display("FAIL cnt_req_en got=%b exp=%b", en[3], 1'b1); end
    tick(1);
    checks++; if (ack[3] !== 1'b1) begin errors++; $display("FAIL cnt_req_ack1 got=%b exp=%b", ack[3], 1'b1); end
    req = 4'b0000; idle = 4'b0110;
    tick(1);
    checks++; if (ack[3] !== 1'b0) begin errors++; $display("FAIL cnt_req_fall got=%b exp=%b", ack[3], 1'b0); end
  endtask

  task automatic test_scan_and_sw_en;
    hold = 8'd0; idle = 4'b1110;
    tick(2);
    checks++; if (en[3] !== 1'b0) begin errors++; $display("FAIL ch3_off got=%b exp=%b", en[3], 1'b0); end
    tick(1);
    a3 = g3;
    tick(2);
    checks++; if (g3 !== a3) begin errors++; $display("FAIL gclk3_gated got=%0d exp=%0d", g3 - a3, 0); end
    scan = 1'b1;
    a3 = g3;
    tick(4);
    checks++; if (g3 !== a3 + 4) begin errors++; $display("FAIL scan_gclk got=%0d exp=%0d", g3 - a3, 4); end
    checks++; if (en[3] !== 1'b0) begin errors++; $display("FAIL scan_en got=%b exp=%b", en[3], 1'b0); end
    scan = 1'b0;
    sw_en = 4'b1000;
    tick(3);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      checks++; if (en[3] !== 1'b1) begin errors++; $display("FAIL sw_en_hold k=%0d got=%b exp=%b", k, en[3], 1'b1); end
    end
    sw_en = 4'b0000; idle = 4'b0110;
    tick(1);
  endtask

  task automatic test_reset_mid_wake;
    req = 4'b0100;
    tick(1);
    checks++; if (en[2] !== 1'b1) begin errors++; $display("FAIL rw_wake got=%b exp=%b", en[2], 1'b1); end
    rst = 1'b1;
    tick(1);
    checks++; if (en !== 4'hF) begin errors++; $display("FAIL rw_en got=%h exp=%h", en, 4'hF); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL rw_ack got=%h exp=%h", ack, 4'h0); end
    rst = 1'b0; req = 4'b0000; idle = 4'b0100; hold = 8'd0;
    tick(1);
    checks++; if (en !== 4'hF) begin errors++; $display("FAIL rw_h0_hold got=%b exp=%b", en, 4'hF); end
    tick(1);
    checks++; if (en !== 4'b1011) begin errors++; $display("FAIL rw_h0_drop got=%b exp=%b", en, 4'b1011); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL rw_ack_after got=%h exp=%h", ack, 4'h0); end
  endtask

  task automatic test_hold_max;
    hold = 8'd255; idle = 4'b0101;
    tick(1);
    tick(255);
    checks++; if (en[0] !== 1'b1) begin errors++; $display("FAIL hmax_hold got=%b exp=%b", en[0], 1'b1); end
    tick(1);
    checks++; if (en !== 4'b1010) begin errors++; $display("FAIL hmax_drop got=%b exp=%b", en, 4'b1010); end
  endtask

  initial begin
    test_reset();
    test_gating();
    test_abort();
    test_wake_handshake();
    test_req_during_count();
    test_scan_and_sw_en();
    test_reset_mid_wake();
    test_hold_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
